// File: rtl/line_pkg.sv
// Shared definitions for the line raster engine.
// Holds the FSM state encoding and the default coordinate width.
package line_pkg;

   localparam int LINE_WIDTH = 13;

   typedef logic [1:0] line_state_t;

   localparam line_state_t IDLE  = 2'd0;
   localparam line_state_t SETUP = 2'd1;
   localparam line_state_t DRAW  = 2'd2;
   localparam line_state_t DONE  = 2'd3;

endpackage

// File: rtl/line_octant_setup.sv
// Combinational octant normalisation for a Bresenham line.
// In: x0,y0,x1,y1 (signed). Out: steep flag, normalised start/end,
// deltax, |deltay|, ystep direction (ystep_neg=1 means -1).
module line_octant_setup
   import line_pkg::*;
#(
   parameter int WIDTH = LINE_WIDTH
) (
   input  logic signed [WIDTH-1:0] x0,
   input  logic signed [WIDTH-1:0] y0,
   input  logic signed [WIDTH-1:0] x1,
   input  logic signed [WIDTH-1:0] y1,
   output logic                    steep,
   output logic signed [WIDTH-1:0] sx0,
   output logic signed [WIDTH-1:0] sy0,
   output logic signed [WIDTH-1:0] sx1,
   output logic        [WIDTH:0]   deltax,
   output logic        [WIDTH:0]   deltay,
   output logic                    ystep_neg
);

   logic signed [WIDTH:0]   dx_raw;
   logic signed [WIDTH:0]   dy_raw;
   logic        [WIDTH:0]   dx_abs;
   logic        [WIDTH:0]   dy_abs;
   logic signed [WIDTH-1:0] ax0, ay0, ax1, ay1;
   logic signed [WIDTH-1:0] bx0, by0, bx1, by1;
   logic                    swap;
   logic signed [WIDTH:0]   ndy_raw;

   always_comb begin
      // differences carried one bit wider so full-range spans never wrap
      dx_raw = {x1[WIDTH-1], x1} - {x0[WIDTH-1], x0};
      dy_raw = {y1[WIDTH-1], y1} - {y0[WIDTH-1], y0};
      dx_abs = dx_raw[WIDTH] ? -dx_raw : dx_raw;
      dy_abs = dy_raw[WIDTH] ? -dy_raw : dy_raw;
      steep  = dy_abs > dx_abs;

      ax0 = steep ? y0 : x0;
      ay0 = steep ? x0 : y0;
      ax1 = steep ? y1 : x1;
      ay1 = steep ? x1 : y1;

      swap = ax0 > ax1;
      bx0  = swap ? ax1 : ax0;
      by0  = swap ? ay1 : ay0;
      bx1  = swap ? ax0 : ax1;
      by1  = swap ? ay0 : ay1;

      deltax  = {bx1[WIDTH-1], bx1} - {bx0[WIDTH-1], bx0};
      ndy_raw = {by1[WIDTH-1], by1} - {by0[WIDTH-1], by0};
      deltay  = ndy_raw[WIDTH] ? -ndy_raw : ndy_raw;

      ystep_neg = !(by0 < by1);
      sx0       = bx0;
      sy0       = by0;
      sx1       = bx1;
   end

endmodule

// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser with a valid/ready pixel stream.
// In: start + signed endpoints, pix_ready. Out: busy, pix_valid,
// pix_x/pix_y (caller orientation), pix_last, done pulse.
module line_raster_engine
   import line_pkg::*;
#(
   parameter int WIDTH = LINE_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] x0,
   input  logic signed [WIDTH-1:0] y0,
   input  logic signed [WIDTH-1:0] x1,
   input  logic signed [WIDTH-1:0] y1,
   output logic                    busy,
   output logic                    pix_valid,
   input  logic                    pix_ready,
   output logic signed [WIDTH-1:0] pix_x,
   output logic signed [WIDTH-1:0] pix_y,
   output logic                    pix_last,
   output logic                    done
);

   localparam logic signed [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   line_state_t state_q, state_d;

   logic signed [WIDTH-1:0] ex0_q, ex0_d;
   logic signed [WIDTH-1:0] ey0_q, ey0_d;
   logic signed [WIDTH-1:0] ex1_q, ex1_d;
   logic signed [WIDTH-1:0] ey1_q, ey1_d;

   logic                    steep_q, steep_d;
   logic                    ystep_neg_q, ystep_neg_d;
   logic signed [WIDTH-1:0] x_q, x_d;
   logic signed [WIDTH-1:0] y_q, y_d;
   logic signed [WIDTH-1:0] xend_q, xend_d;
   logic        [WIDTH:0]   deltax_q, deltax_d;
   logic        [WIDTH:0]   deltay_q, deltay_d;
   logic signed [WIDTH+1:0] err_q, err_d;

   logic                    su_steep;
   logic signed [WIDTH-1:0] su_x0, su_y0, su_x1;
   logic        [WIDTH:0]   su_deltax, su_deltay;
   logic                    su_ystep_neg;

   logic signed [WIDTH+1:0] err_m;
   logic signed [WIDTH+1:0] dx_ext;
   logic signed [WIDTH+1:0] dy_ext;
   logic                    at_end;

   line_octant_setup #(
      .WIDTH(WIDTH)
   ) u_setup (
      .x0       (ex0_q),
      .y0       (ey0_q),
      .x1       (ex1_q),
      .y1       (ey1_q),
      .steep    (su_steep),
      .sx0      (su_x0),
      .sy0      (su_y0),
      .sx1      (su_x1),
      .deltax   (su_deltax),
      .deltay   (su_deltay),
      .ystep_neg(su_ystep_neg)
   );

   assign dx_ext = {1'b0, deltax_q};
   assign dy_ext = {1'b0, deltay_q};
   assign at_end = x_q == xend_q;

   always_comb begin
      state_d     = state_q;
      ex0_d       = ex0_q;
      ey0_d       = ey0_q;
      ex1_d       = ex1_q;
      ey1_d       = ey1_q;
      steep_d     = steep_q;
      ystep_neg_d = ystep_neg_q;
      x_d         = x_q;
      y_d         = y_q;
      xend_d      = xend_q;
      deltax_d    = deltax_q;
      deltay_d    = deltay_q;
      err_d       = err_q;
      err_m       = err_q - dy_ext;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               ex0_d   = x0;
               ey0_d   = y0;
               ex1_d   = x1;
               ey1_d   = y1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            steep_d     = su_steep;
            ystep_neg_d = su_ystep_neg;
            x_d         = su_x0;
            y_d         = su_y0;
            xend_d      = su_x1;
            deltax_d    = su_deltax;
            deltay_d    = su_deltay;
            // deltax is non-negative, so >>>1 is a plain halving
            err_d       = {2'b00, su_deltax[WIDTH:1]};
            state_d     = DRAW;
         end
         DRAW: begin
            if (pix_ready) begin
               if (at_end) begin
                  state_d = DONE;
               end else begin
                  if (err_m < 0) begin
                     y_d   = ystep_neg_q ? y_q - ONE : y_q + ONE;
                     err_d = err_m + dx_ext;
                  end else begin
                     err_d = err_m;
                  end
                  x_d = x_q + ONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ex0_q       <= '0;
         ey0_q       <= '0;
         ex1_q       <= '0;
         ey1_q       <= '0;
         steep_q     <= 1'b0;
         ystep_neg_q <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         xend_q      <= '0;
         deltax_q    <= '0;
         deltay_q    <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         ex0_q       <= ex0_d;
         ey0_q       <= ey0_d;
         ex1_q       <= ex1_d;
         ey1_q       <= ey1_d;
         steep_q     <= steep_d;
         ystep_neg_q <= ystep_neg_d;
         x_q         <= x_d;
         y_q         <= y_d;
         xend_q      <= xend_d;
         deltax_q    <= deltax_d;
         deltay_q    <= deltay_d;
         err_q       <= err_d;
      end
   end

   assign busy      = state_q != IDLE;
   assign pix_valid = state_q == DRAW;
   assign pix_last  = pix_valid && at_end;
   assign done      = state_q == DONE;
   // internal walk is always along x; undo the steep transpose
   assign pix_x     = steep_q ? y_q : x_q;
   assign pix_y     = steep_q ? x_q : y_q;

endmodule

// File: tb/tb_line_raster_engine.sv
// Self-checking bench for line_raster_engine.
// Directed table, stall/reset sequences and randomised lines vs a model.
module tb_line_raster_engine;

   localparam int W = 13;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic signed [W-1:0] x0, y0, x1, y1;
   logic                busy, pix_valid, pix_ready, pix_last, done;
   logic signed [W-1:0] pix_x, pix_y;

   line_raster_engine #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .x0       (x0),
      .y0       (y0),
      .x1       (x1),
      .y1       (y1),
      .busy     (busy),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .pix_x    (pix_x),
      .pix_y    (pix_y),
      .pix_last (pix_last),
      .done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x0; int y0; int x1; int y1;
      int n;
      int ex[8];
      int ey[8];
   } vec_t;

   int checks = 0;
   int errors = 0;
   int gx[$], gy[$], gl[$];
   int ex_q[$], ey_q[$];
   int lat, done_gap, busy_after, done_after, hold_bad;
   bit tmo;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return v < 0 ? -v : v;
   endfunction

   // closed form: after i major steps the minor axis has advanced
   // ceil((i*dy - floor(dx/2)) / dx) times
   function automatic void model(input int ax0, ay0, ax1, ay1);
      int a0, b0, a1, b1, t, dx, dy, ys, h, k;
      bit steep;
      ex_q.delete();
      ey_q.delete();
      steep = iabs(ay1 - ay0) > iabs(ax1 - ax0);
      a0 = steep ? ay0 : ax0;
      b0 = steep ? ax0 : ay0;
      a1 = steep ? ay1 : ax1;
      b1 = steep ? ax1 : ay1;
      if (a0 > a1) begin
         t = a0; a0 = a1; a1 = t;
         t = b0; b0 = b1; b1 = t;
      end
      dx = a1 - a0;
      dy = iabs(b1 - b0);
      ys = (b0 < b1) ? 1 : -1;
      h  = dx / 2;
      for (int i = 0; i <= dx; i++) begin
         k = (dx == 0) ? 0 : (i * dy - h + dx - 1) / dx;
         if (steep) begin
            ex_q.push_back(b0 + ys * k);
            ey_q.push_back(a0 + i);
         end else begin
            ex_q.push_back(a0 + i);
            ey_q.push_back(b0 + ys * k);
         end
      end
   endfunction

   task automatic run_line(input int ax0, ay0, ax1, ay1,
                           input int stall_idx, input int stall_len,
                           input bit rnd, input bit poke);
      int cyc, last_cyc, stalled, hx, hy, hl;
      bit rdy;
      gx.delete(); gy.delete(); gl.delete();
      lat = -1; done_gap = -1; busy_after = -1; done_after = -1;
      hold_bad = 0; tmo = 0;
      x0 = ax0[W-1:0]; y0 = ay0[W-1:0];
      x1 = ax1[W-1:0]; y1 = ay1[W-1:0];
      start = 1'b1;
      pix_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      x0 = W'($urandom); y0 = W'($urandom);
      x1 = W'($urandom); y1 = W'($urandom);
      cyc = 1; last_cyc = -100; stalled = 0; hx = 0; hy = 0; hl = 0;
      forever begin
         start = 1'b0;
         if (cyc > 40000) begin
            tmo = 1'b1;
            break;
         end
         if (done) begin
            done_gap = cyc - last_cyc;
            break;
         end
         rdy = 1'b1;
         if (pix_valid) begin
            if (lat < 0) lat = cyc;
            if (gx.size() == stall_idx && stalled < stall_len) begin
               rdy = 1'b0;
               if (stalled == 0) begin
                  hx = int'(pix_x); hy = int'(pix_y); hl = int'(pix_last);
               end else if (int'(pix_x) != hx || int'(pix_y) != hy ||
                            int'(pix_last) != hl) begin
                  hold_bad++;
               end
               stalled++;
               if (poke && stalled == 2) begin
                  start = 1'b1;
                  x0 = 9; y0 = -9; x1 = -9; y1 = 9;
               end
            end else if (rnd) begin
               rdy = $urandom_range(0, 2) != 0;
            end
            pix_ready = rdy;
            if (rdy) begin
               gx.push_back(int'(pix_x));
               gy.push_back(int'(pix_y));
               gl.push_back(int'(pix_last));
               if (pix_last) last_cyc = cyc;
            end
         end else begin
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      pix_ready = 1'b1;
      @(negedge clk);
      busy_after = int'(busy);
      done_after = int'(done);
   endtask

   task automatic verify(input string tag);
      int n, lsum;
      check({tag, " timeout"}, int'(tmo), 0);
      check({tag, " count"}, gx.size(), ex_q.size());
      n = gx.size() < ex_q.size() ? gx.size() : ex_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s px%0d.x", tag, i), gx[i], ex_q[i]);
         check($sformatf("%s px%0d.y", tag, i), gy[i], ey_q[i]);
      end
      lsum = 0;
      foreach (gl[i]) lsum += gl[i];
      check({tag, " last_count"}, lsum, 1);
      if (gl.size() > 0) check({tag, " last_pos"}, gl[gl.size()-1], 1);
      check({tag, " latency"}, lat, 2);
      check({tag, " done_gap"}, done_gap, 1);
      check({tag, " done_width"}, done_after, 0);
      check({tag, " idle_after"}, busy_after, 0);
   endtask

   vec_t tbl[4];
   int nxfer;
   int rx0, ry0, rx1, ry1;

   initial begin
      tbl[0] = '{0, 0, 5, 2, 6, '{0, 1, 2, 3, 4, 5, 0, 0},
                                '{0, 0, 1, 1, 2, 2, 0, 0}};
      tbl[1] = '{2, 5, 0, 0, 6, '{0, 0, 1, 1, 2, 2, 0, 0},
                                '{0, 1, 2, 3, 4, 5, 0, 0}};
      tbl[2] = '{0, 3, 3, 0, 4, '{0, 1, 2, 3, 0, 0, 0, 0},
                                '{3, 2, 1, 0, 0, 0, 0, 0}};
      tbl[3] = '{7, 7, 7, 7, 1, '{7, 0, 0, 0, 0, 0, 0, 0},
                                '{7, 0, 0, 0, 0, 0, 0, 0}};

      rst = 1'b1; start = 1'b0; pix_ready = 1'b1;
      x0 = 0; y0 = 0; x1 = 0; y1 = 0;
      #1;
      check("rst busy", int'(busy), 0);
      check("rst pix_valid", int'(pix_valid), 0);
      check("rst pix_last", int'(pix_last), 0);
      check("rst done", int'(done), 0);
      check("rst pix_x", int'(pix_x), 0);
      check("rst pix_y", int'(pix_y), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 4; t++) begin
         ex_q.delete(); ey_q.delete();
         for (int i = 0; i < tbl[t].n; i++) begin
            ex_q.push_back(tbl[t].ex[i]);
            ey_q.push_back(tbl[t].ey[i]);
         end
         run_line(tbl[t].x0, tbl[t].y0, tbl[t].x1, tbl[t].y1, -1, 0, 0, 0);
         verify($sformatf("tbl%0d", t));
      end

      // stall 3 cycles on the second pixel, poke start while busy
      ex_q.delete(); ey_q.delete();
      for (int i = 0; i < 6; i++) begin
         ex_q.push_back(tbl[0].ex[i]);
         ey_q.push_back(tbl[0].ey[i]);
      end
      run_line(0, 0, 5, 2, 1, 3, 0, 1);
      verify("stall");
      check("stall hold", hold_bad, 0);

      // asynchronous reset while the third pixel is presented
      x0 = 0; y0 = 0; x1 = 5; y1 = 2;
      start = 1'b1; pix_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nxfer = 0;
      for (int c = 0; c < 20 && nxfer < 2; c++) begin
         if (pix_valid) nxfer++;
         @(negedge clk);
      end
      check("rst mid reached", int'(pix_valid), 1);
      #2 rst = 1'b1;
      #1;
      check("rst mid busy", int'(busy), 0);
      check("rst mid valid", int'(pix_valid), 0);
      check("rst mid last", int'(pix_last), 0);
      check("rst mid done", int'(done), 0);
      check("rst mid pix_x", int'(pix_x), 0);
      check("rst mid pix_y", int'(pix_y), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post rst done", int'(done), 0);
      check("post rst busy", int'(busy), 0);
      ex_q = '{0, 1};
      ey_q = '{0, 1};
      run_line(0, 0, 1, 1, -1, 0, 0, 0);
      verify("after_rst");

      // randomised short lines, some with random back-pressure
      for (int r = 0; r < 40; r++) begin
         rx0 = $urandom_range(0, 40) - 20;
         ry0 = $urandom_range(0, 40) - 20;
         rx1 = $urandom_range(0, 40) - 20;
         ry1 = $urandom_range(0, 40) - 20;
         model(rx0, ry0, rx1, ry1);
         run_line(rx0, ry0, rx1, ry1, -1, 0, r >= 25, 0);
         verify($sformatf("rnd%0d", r));
      end

      // full-range extremes and a couple of wide random lines
      model(-4096, -4096, 4095, 4095);
      run_line(-4096, -4096, 4095, 4095, -1, 0, 0, 0);
      verify("ext0");
      model(4095, -4096, -4096, 3000);
      run_line(4095, -4096, -4096, 3000, -1, 0, 0, 0);
      verify("ext1");
      for (int r = 0; r < 3; r++) begin
         rx0 = $urandom_range(0, 8191) - 4096;
         ry0 = $urandom_range(0, 8191) - 4096;
         rx1 = $urandom_range(0, 8191) - 4096;
         ry1 = $urandom_range(0, 8191) - 4096;
         model(rx0, ry0, rx1, ry1);
         run_line(rx0, ry0, rx1, ry1, -1, 0, 0, 0);
         verify($sformatf("wide%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
